// File: rtl/alu_serial_if.sv
// Operation/result handshake bundle for alu_serial.
//   master: upstream + result consumer (drives in_valid, alu_ctl, op_a, op_b, out_ready)
//   slave : the ALU (drives in_ready, out_valid, result, zero, illegal)
interface alu_serial_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, alu_ctl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_ctl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_serial.sv
// alu_pkg: ALUCtl operation codes; any other 4-bit value is illegal.
package alu_pkg;
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_SLL = 4'h2;
    localparam logic [3:0] ALU_SLT = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_SRL = 4'h5;
    localparam logic [3:0] ALU_SRA = 4'h6;
    localparam logic [3:0] ALU_OR  = 4'h7;
    localparam logic [3:0] ALU_AND = 4'h8;
endpackage

// alu_serial: execute-stage ALU. Logic/arith/compare finish in one cycle;
// shifts run through a 1-bit-per-cycle serial shifter.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - alu_serial_if.slave: in_valid/in_ready, alu_ctl, op_a, op_b,
//           out_valid/out_ready, result, zero, illegal (all outputs registered)
module alu_serial
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_serial_if.slave  bus
);
    localparam int unsigned SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] shreg_q, shreg_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [3:0]      sop_q, sop_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    logic [SHW-1:0]  amt_c;
    logic            is_shift_c;
    logic [XLEN-1:0] alu_c;
    logic            alu_ill_c;
    logic [XLEN-1:0] shstep_c;
    logic            slt_c;

    assign amt_c      = bus.op_b[SHW-1:0];
    assign is_shift_c = (bus.alu_ctl == ALU_SLL) || (bus.alu_ctl == ALU_SRL) ||
                        (bus.alu_ctl == ALU_SRA);
    assign slt_c      = $signed(bus.op_a) < $signed(bus.op_b);

    // Single-cycle datapath; shift codes pass op_a through for amount 0.
    always_comb begin
        alu_c     = '0;
        alu_ill_c = 1'b0;
        case (bus.alu_ctl)
            ALU_ADD: alu_c = bus.op_a + bus.op_b;
            ALU_SUB: alu_c = bus.op_a - bus.op_b;
            ALU_SLT: alu_c = {{(XLEN-1){1'b0}}, slt_c};
            ALU_XOR: alu_c = bus.op_a ^ bus.op_b;
            ALU_OR:  alu_c = bus.op_a | bus.op_b;
            ALU_AND: alu_c = bus.op_a & bus.op_b;
            ALU_SLL: alu_c = bus.op_a;
            ALU_SRL: alu_c = bus.op_a;
            ALU_SRA: alu_c = bus.op_a;
            default: alu_ill_c = 1'b1;
        endcase
    end

    // One-bit step of the serial shifter for the latched shift kind.
    always_comb begin
        shstep_c = shreg_q;
        case (sop_q)
            ALU_SLL: shstep_c = {shreg_q[XLEN-2:0], 1'b0};
            ALU_SRL: shstep_c = {1'b0, shreg_q[XLEN-1:1]};
            ALU_SRA: shstep_c = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
            default: shstep_c = shreg_q;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        sop_d       = sop_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (is_shift_c && (amt_c != '0)) begin
                        shreg_d = bus.op_a;
                        cnt_d   = amt_c;
                        sop_d   = bus.alu_ctl;
                        state_d = SHIFT;
                    end else begin
                        result_d  = alu_c;
                        zero_d    = (alu_c == '0);
                        illegal_d = alu_ill_c;
                        state_d   = DONE;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shstep_c;
                cnt_d   = cnt_q - SHW'(1);
                // Counter at 1 means this edge applies the last bit of shift.
                if (cnt_q == SHW'(1)) begin
                    result_d  = shstep_c;
                    zero_d    = (shstep_c == '0);
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            sop_q       <= ALU_ADD;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            sop_q       <= sop_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_serial.sv
// Directed + randomized checks of alu_serial against a plain-arithmetic model.
module tb_alu_serial;
    import alu_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk;
    logic rst_n;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    alu_serial_if #(.XLEN(XLEN)) bus ();

    alu_serial #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: result, illegal flag and accept-to-out_valid latency.
    function automatic void model(input logic [3:0] ctl, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic ill, output int lat);
        int unsigned n;
        n   = b % XLEN;
        ill = 1'b0;
        lat = 1;
        case (ctl)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_XOR: r = a ^ b;
            ALU_OR:  r = a | b;
            ALU_AND: r = a & b;
            ALU_SLL: begin r = a << n; lat = (n == 0) ? 1 : int'(n) + 1; end
            ALU_SRL: begin r = a >> n; lat = (n == 0) ? 1 : int'(n) + 1; end
            ALU_SRA: begin r = $unsigned($signed(a) >>> n); lat = (n == 0) ? 1 : int'(n) + 1; end
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    // Called right after the accept edge; waits for the result and retires it.
    task automatic wait_result(input logic [3:0] ctl, input logic [31:0] a,
                               input logic [31:0] b, input string tag);
        logic [31:0] er;
        logic        eill;
        int          elat;
        int          lat;
        logic        rdy_seen;
        model(ctl, a, b, er, eill, elat);
        lat      = 1;
        rdy_seen = 1'b0;
        // Operands changing after accept must not matter.
        bus.op_a    = $urandom;
        bus.op_b    = $urandom;
        bus.alu_ctl = 4'($urandom_range(0, 15));
        while (!bus.out_valid && lat < 40) begin
            rdy_seen |= bus.in_ready;
            step();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_busy_in_ready"}, 64'(rdy_seen), 64'(0));
        chk({tag, "_result"}, 64'(bus.result), 64'(er));
        chk({tag, "_zero"}, 64'(bus.zero), 64'(er == 32'd0));
        chk({tag, "_illegal"}, 64'(bus.illegal), 64'(eill));
        bus.out_ready = 1'b1;
        step();
        chk({tag, "_retire_valid"}, 64'(bus.out_valid), 64'(0));
        chk({tag, "_retire_ready"}, 64'(bus.in_ready), 64'(1));
    endtask

    task automatic run_op(input logic [3:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        bus.alu_ctl   = ctl;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_result(ctl, a, b, tag);
    endtask

    initial begin
        logic seen;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_ctl   = 4'h0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b0;
        step();
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_result", 64'(bus.result), 64'(0));
        chk("rst_zero", 64'(bus.zero), 64'(0));
        chk("rst_illegal", 64'(bus.illegal), 64'(0));
        rst_n = 1'b1;
        step();

        run_op(ALU_ADD, 32'hFFFF_FFFF, 32'd1, "add_wrap");
        run_op(ALU_SUB, 32'd5, 32'd7, "sub_neg");
        run_op(ALU_SRA, 32'h8000_0000, 32'd4, "sra4");
        run_op(ALU_SRL, 32'h8000_0000, 32'd4, "srl4");
        run_op(ALU_SLL, 32'd1, 32'd31, "sll31");
        run_op(ALU_SLT, 32'hFFFF_FFFD, 32'd2, "slt_lt");
        run_op(ALU_SLT, 32'd2, 32'hFFFF_FFFD, "slt_ge");
        run_op(ALU_SLL, 32'h1234, 32'd0, "sll0");
        run_op(ALU_SRL, 32'hF000_000F, 32'd33, "srl_amt_hi_ignored");
        chk("srl33_const", 64'(bus.result), 64'(32'h7800_0007));

        // Backpressure: result held, no accepts while DONE stalls.
        bus.alu_ctl   = ALU_AND;
        bus.op_a      = 32'hF0F0;
        bus.op_b      = 32'hFF00;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        step();
        chk("bp_valid", 64'(bus.out_valid), 64'(1));
        chk("bp_result0", 64'(bus.result), 64'(32'hF000));
        for (int i = 0; i < 10; i++) begin
            bus.alu_ctl = 4'($urandom_range(0, 8));
            bus.op_a    = $urandom;
            bus.op_b    = $urandom;
            step();
            chk("bp_hold_result", 64'(bus.result), 64'(32'hF000));
            chk("bp_hold_ready", 64'(bus.in_ready), 64'(0));
            chk("bp_hold_valid", 64'(bus.out_valid), 64'(1));
        end
        bus.alu_ctl   = ALU_ADD;
        bus.op_a      = 32'd100;
        bus.op_b      = 32'd23;
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_ready", 64'(bus.in_ready), 64'(1));
        chk("bp_release_valid", 64'(bus.out_valid), 64'(0));
        step();
        bus.in_valid = 1'b0;
        wait_result(ALU_ADD, 32'd100, 32'd23, "bp_pending_add");

        run_op(4'hF, 32'h1234, 32'h5678, "illegal15");
        run_op(ALU_XOR, 32'hA5, 32'hFF, "xor_after_illegal");

        // Reset on the 3rd cycle of a 20-bit shift aborts it.
        bus.alu_ctl  = ALU_SLL;
        bus.op_a     = 32'h0000_0F0F;
        bus.op_b     = 32'd20;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_in_ready", 64'(bus.in_ready), 64'(1));
        chk("abort_valid", 64'(bus.out_valid), 64'(0));
        chk("abort_result", 64'(bus.result), 64'(0));
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            seen |= bus.out_valid;
            step();
        end
        chk("abort_no_valid", 64'(seen), 64'(0));
        run_op(ALU_ADD, 32'd2, 32'd3, "add_after_reset");
        chk("add_after_reset_const", 64'(bus.result), 64'(5));

        // Randomized operations over the full 4-bit code space.
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op(c, a, b, "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_serial.md
# alu_serial

Execute-stage ALU that consumes the 4-bit `ALUCtl` code from the ALU control decoder plus two operands and produces a registered result with a zero flag for branch resolution. Logic, arithmetic and compare ops complete in one cycle. Shifts use a 1-bit-per-cycle serial shifter to save FPGA area. Valid/ready handshakes sit on both sides, so the block can be stalled by writeback.

## Interface
- `XLEN`, 32: operand/result width; power of two, ≥ 8.
- `SHW`, $clog2(XLEN): shift-amount width (derived; do not override).

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  block can accept an operation.
- `alu_ctl`  in  4  operation code; `alu_pkg` values (`ALU_ADD`, `ALU_SUB`, `ALU_SLL`, `ALU_SLT`, `ALU_XOR`, `ALU_SRL`, `ALU_SRA`, `ALU_OR`, `ALU_AND`).
- `op_a`  in  XLEN  first operand.
- `op_b`  in  XLEN  second operand; shift amount is `op_b[SHW-1:0]`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `result`  out  XLEN  operation result.
- `zero`  out  1  `result == 0`.
- `illegal`  out  1  `alu_ctl` was not a defined `alu_pkg` code (including 15).

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- `in_ready` = (state == IDLE). Accept means `in_valid && in_ready` on a rising edge.
- Accept of a non-shift op, or a shift with amount 0:
  - compute result and register it;
  - go to DONE.
- Accept of `ALU_SLL`/`ALU_SRL`/`ALU_SRA` with amount n > 0:
  - load `op_a` into the shift register and n into a down-counter;
  - go to SHIFT.
- SHIFT:
  - each cycle, shift 1 bit and decrement the counter;
  - SLL fills with 0, SRL fills with 0, SRA fills with bit XLEN-1 (sign);
  - when the counter reaches 1, perform the final shift and go to DONE.
- DONE: `out_valid`=1. On `out_ready`=1, go to IDLE. A new accept is only possible from IDLE, so there is no overlap.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^XLEN with no carry/overflow output.
  - SLT is a signed two's-complement compare, producing 1 or 0 zero-extended.
  - AND, OR and XOR are bitwise.
- Undefined code: `result`=0, `zero`=1, `illegal`=1, latency 1 (treated as a non-shift op).
- `zero` and `illegal` are registered together with `result`.
- Outputs hold stable while `out_valid && !out_ready`.
- In IDLE and SHIFT, `result`/`zero`/`illegal` keep their last DONE values. Consumers must qualify them with `out_valid`.

## Timing
- Reset values, applied on the first rising edge with `rst_n`=0:
  - state IDLE;
  - `out_valid`=0, `result`=0, `zero`=0, `illegal`=0, shift counter 0;
  - `in_ready`=1 from the cycle after that edge.
- Reset dominates every other event. Reset asserted in SHIFT or DONE aborts the op, and no result is ever presented for it.
- Latency from accept edge to `out_valid` high:
  - 1 cycle for non-shift ops and for shift amount 0;
  - n+1 cycles for shift amount n (max XLEN).
- Throughput: one op per (latency + 1) cycles at best, because DONE→IDLE costs one cycle even with `out_ready` held high.
- `in_valid` during SHIFT/DONE is ignored. The upstream must hold `in_valid` and its operands until it sees `in_ready`.
- Operands are sampled only at the accept edge. Changing `op_a`/`op_b`/`alu_ctl` afterwards has no effect on the op in flight.
- Shift amount uses only the low SHW bits of `op_b`; upper bits are ignored (for example, `op_b`=33 with XLEN=32 shifts by 1).

## Test plan
- ADD `op_a`=0xFFFFFFFF, `op_b`=1 → 1 cycle later `out_valid`=1, `result`=0, `zero`=1, `illegal`=0. Then SUB 5−7 → `result`=0xFFFFFFFE, `zero`=0.
- SRA `op_a`=0x80000000, `op_b`=4 → `out_valid` 5 cycles after accept with `result`=0xF8000000. `in_ready`=0 throughout. Repeat with SRL → 0x08000000, and SLL of 1 by 31 → 0x80000000 after 32 cycles.
- SLT with −3 vs 2 → `result`=1. SLT with 2 vs −3 → `result`=0. Shift amount 0 (SLL 0x1234, 0) → `result`=0x1234 at latency 1.
- Backpressure: after AND 0xF0F0&0xFF00 (`result`=0xF000), hold `out_ready`=0 for 10 cycles while driving new `in_valid` ops with changing operands. `result` stays 0xF000 and nothing is accepted. `out_ready`=1 → IDLE next cycle, then the pending op is accepted.
- `alu_ctl`=15 → latency 1, `result`=0, `zero`=1, `illegal`=1. A following legal XOR 0xA5^0xFF → `result`=0x5A, `illegal`=0.
- Drop `rst_n` for one cycle on the 3rd cycle of an SLL-by-20 → no `out_valid` ever appears for that op, `in_ready`=1 the cycle after reset, `result`=0. A new ADD 2+3 completes with `result`=5.
